usb_bulk_out_ep: RTL and testbench
==================================

Name: usb_bulk_out_ep

Overview:
- Bulk OUT endpoint receiver that sits directly downstream of the `usb` core, beside the control-endpoint logic in top.
- Claims OUT transactions addressed to endpoint `EP_NUM` and drives the handshake and expected data toggle for them.
- Buffers payload bytes speculatively and commits a packet only when the core reports a good CRC.
- Committed bytes go out through a show-ahead FIFO read port that feeds the UART byte queue.

Parameters:
- EP_NUM, 2: endpoint number served (4-bit compare).
- DEPTH_LOG2, 7: buffer holds 2^DEPTH_LOG2 bytes (128).
- MAX_PKT, 64: maximum accepted payload; must be less than 2^DEPTH_LOG2.

Ports:
- clk48mhz  in  1  system clock.
- rst  in  1  reset; synchronous, active-low.
- usb_rst  in  1  bus reset from the usb core; same effect as rst.
- ep_enable  in  1  endpoint configured (set after SET_CONFIGURATION).
- ep_halt  in  1  endpoint halted; forces STALL.
- transaction_active  in  1  usb core transaction in progress.
- endpoint  in  4  token endpoint.
- direction_in  in  1  token is IN.
- setup  in  1  token is SETUP.
- data_strobe  in  1  a new byte is valid on data_out (rising edge).
- data_out  in  8  received byte.
- success  in  1  packet CRC is good and the handshake was sent.
- handshake  out  2  00 ACK, 01 none, 10 NAK, 11 STALL.
- data_toggle  out  1  expected DATA0/DATA1 for this endpoint.
- claim  out  1  high while this block owns the current transaction; top muxes handshake and data_toggle with it.
- fifo_empty  out  1  no committed bytes.
- fifo_data  out  8  head byte; show-ahead, valid whenever fifo_empty=0.
- fifo_pop  in  1  consume the head byte; ignored when empty.
- fifo_count  out  DEPTH_LOG2+1  committed byte count.

Behaviour:
- Reset (rst=0 or usb_rst=1, sampled on clk48mhz):
  - state IDLE; all pointers and counts 0; data_toggle=0; handshake=01; claim=0; fifo_empty=1; fifo_data=0.
  - Takes priority over every other event, including a transaction in progress.
- Edge detection: transaction_active and data_strobe are registered; a start is transaction_active rising, a byte is data_strobe rising.
- Pointers:
  - wr_commit and rd_ptr are DEPTH_LOG2+1 bits, wrap modulo 2^(DEPTH_LOG2+1).
  - wr_spec is the speculative write pointer.
  - free = 2^DEPTH_LOG2 − (wr_commit − rd_ptr).
- States:
  - IDLE: on a start with endpoint==EP_NUM, direction_in=0 and setup=0, set claim=1 and choose the handshake:
    - ep_halt=1 → 11 (STALL), go to DRAIN.
    - else ep_enable=0 → 01 (none), go to DRAIN.
    - else free < MAX_PKT → 10 (NAK), go to DRAIN.
    - else → 00 (ACK), wr_spec=wr_commit, len=0, go to RECV.
    - Any other token leaves the block in IDLE with claim=0.
    - handshake is valid the cycle after the start edge and holds until claim falls.
  - RECV: on each byte edge, if len<MAX_PKT write data_out at wr_spec, then increment wr_spec and len; else set ovf=1 and write nothing.
    - success=1 and ovf=0: wr_commit=wr_spec, data_toggle flips, go to DONE.
    - success=1 and ovf=1: no commit, toggle unchanged, go to DONE.
    - transaction_active falls without success: rollback (wr_spec discarded), toggle unchanged, go to IDLE, claim=0.
  - DRAIN: wait for transaction_active low, then claim=0, handshake=01, go to IDLE. Bytes received in DRAIN are ignored.
  - DONE: same exit as DRAIN.
- Commit and pop in the same cycle are both applied. fifo_count reflects both the cycle after.
- Popping while empty has no effect; rd_ptr never passes wr_commit.
- Zero-length packet with success: commits nothing, toggle flips.
- fifo_data is a registered read of the buffer at rd_ptr, or at rd_ptr+1 when a pop occurs. Latency is 1 cycle after a commit or pop.
- ep_halt or ep_enable changing mid-RECV has no effect until the next transaction.

Test Plan:
- OUT to EP2 with 4 bytes 11 22 33 44, then success → handshake=00, data_toggle 0→1, fifo_count=4, fifo_data=11; four pops yield 11 22 33 44, then fifo_empty=1.
- Same packet with transaction_active dropping before success → no commit, fifo_count=0, data_toggle stays 0, next packet lands at the same address.
- Fill with two committed 64-byte packets → next OUT gets handshake=10 with no writes; one pop still leaves free<64, so NAK; after 64 pops the next OUT is ACKed.
- ep_halt=1 → 11 on OUT to EP2; OUT to EP1, IN to EP2 and SETUP → claim stays 0.
- 65-byte packet with success → ovf, no commit, toggle unchanged; pointer wrap exercised with 3×64-byte packets interleaved with pops, data intact.
- usb_rst mid-RECV with 10 committed bytes → fifo_count=0, data_toggle=0, state IDLE on the next cycle.

Source files
------------

// File: rtl/usb_bulk_out_ep.sv
// Bulk OUT endpoint: claims OUT tokens for EP_NUM, buffers payload speculatively,
// commits on good CRC and exposes committed bytes through a show-ahead FIFO port.
//
// state | meaning
// IDLE  | waiting for an OUT token to this endpoint
// RECV  | ACKed; storing payload bytes speculatively
// DRAIN | STALL/NAK/none answered; waiting for the transaction to end
// DONE  | packet finished (committed or dropped); waiting for the transaction to end
module usb_bulk_out_ep #(
   parameter int EP_NUM     = 2,
   parameter int DEPTH_LOG2 = 7,
   parameter int MAX_PKT    = 64
) (
   input  logic                  clk48mhz,
   input  logic                  rst,
   input  logic                  usb_rst,
   input  logic                  ep_enable,
   input  logic                  ep_halt,
   input  logic                  transaction_active,
   input  logic [3:0]            endpoint,
   input  logic                  direction_in,
   input  logic                  setup,
   input  logic                  data_strobe,
   input  logic [7:0]            data_out,
   input  logic                  success,
   output logic [1:0]            handshake,
   output logic                  data_toggle,
   output logic                  claim,
   output logic                  fifo_empty,
   output logic [7:0]            fifo_data,
   input  logic                  fifo_pop,
   output logic [DEPTH_LOG2:0]   fifo_count
);
   localparam int PW = DEPTH_LOG2 + 1;
   localparam int LW = $clog2(MAX_PKT + 1);
   localparam logic [PW:0]   CAPACITY  = (PW+1)'(2**DEPTH_LOG2);
   localparam logic [PW:0]   MAX_PKT_W = (PW+1)'(MAX_PKT);
   localparam logic [LW-1:0] MAX_LEN   = LW'(MAX_PKT);

   localparam logic [1:0] HS_ACK   = 2'b00;
   localparam logic [1:0] HS_NONE  = 2'b01;
   localparam logic [1:0] HS_NAK   = 2'b10;
   localparam logic [1:0] HS_STALL = 2'b11;

   typedef enum logic [1:0] {IDLE, RECV, DRAIN, DONE} state_t;

   state_t          state, state_next;
   logic            ta_q, ds_q;
   logic [PW-1:0]   wr_commit, wr_spec, rd_ptr;
   logic [PW-1:0]   used, rd_next, commit_ptr_next;
   logic [PW:0]     free;
   logic [LW-1:0]   len;
   logic            ovf;
   logic [7:0]      mem [0:(2**DEPTH_LOG2)-1];

   logic            reset_now, start, byte_edge, our_token, pop_ok;
   logic [1:0]      hs_next;
   logic            claim_next, open_pkt, store_byte, mark_ovf, commit, flip;

   assign reset_now = ~rst | usb_rst;
   assign start     = transaction_active & ~ta_q;
   assign byte_edge = data_strobe & ~ds_q;
   assign our_token = start && (endpoint == 4'(EP_NUM)) && !direction_in && !setup;

   assign used            = wr_commit - rd_ptr;
   assign free            = CAPACITY - {1'b0, used};
   assign pop_ok          = fifo_pop && (used != '0);
   assign rd_next         = rd_ptr + PW'(pop_ok);
   assign commit_ptr_next = commit ? wr_spec : wr_commit;

   assign fifo_count = used;
   assign fifo_empty = (used == '0);

   always_comb begin
      state_next = state;
      hs_next    = handshake;
      claim_next = claim;
      open_pkt   = 1'b0;
      store_byte = 1'b0;
      mark_ovf   = 1'b0;
      commit     = 1'b0;
      flip       = 1'b0;
      case (state)
         IDLE: begin
            if (our_token) begin
               claim_next = 1'b1;
               if (ep_halt) begin
                  hs_next    = HS_STALL;
                  state_next = DRAIN;
               end else if (!ep_enable) begin
                  hs_next    = HS_NONE;
                  state_next = DRAIN;
               end else if (free < MAX_PKT_W) begin
                  hs_next    = HS_NAK;
                  state_next = DRAIN;
               end else begin
                  hs_next    = HS_ACK;
                  open_pkt   = 1'b1;
                  state_next = RECV;
               end
            end
         end
         RECV: begin
            if (success) begin
               commit     = ~ovf;
               flip       = ~ovf;
               state_next = DONE;
            end else if (!transaction_active) begin
               // Rollback is implicit: wr_spec is reloaded from wr_commit on the next ACK.
               claim_next = 1'b0;
               hs_next    = HS_NONE;
               state_next = IDLE;
            end else if (byte_edge) begin
               if (len < MAX_LEN) store_byte = 1'b1;
               else               mark_ovf   = 1'b1;
            end
         end
         DRAIN, DONE: begin
            if (!transaction_active) begin
               claim_next = 1'b0;
               hs_next    = HS_NONE;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk48mhz) begin
      if (reset_now) begin
         state       <= IDLE;
         handshake   <= HS_NONE;
         claim       <= 1'b0;
         data_toggle <= 1'b0;
         wr_commit   <= '0;
         wr_spec     <= '0;
         rd_ptr      <= '0;
         len         <= '0;
         ovf         <= 1'b0;
         fifo_data   <= 8'h00;
      end else begin
         state     <= state_next;
         handshake <= hs_next;
         claim     <= claim_next;
         if (open_pkt) begin
            wr_spec <= wr_commit;
            len     <= '0;
            ovf     <= 1'b0;
         end else if (store_byte) begin
            wr_spec <= wr_spec + PW'(1);
            len     <= len + LW'(1);
         end
         if (mark_ovf) ovf <= 1'b1;
         if (commit) wr_commit <= wr_spec;
         if (flip) data_toggle <= ~data_toggle;
         rd_ptr <= rd_next;
         // Show-ahead head register; held at zero whenever nothing is committed.
         fifo_data <= (commit_ptr_next == rd_next) ? 8'h00 : mem[rd_next[DEPTH_LOG2-1:0]];
      end
   end

   always_ff @(posedge clk48mhz) begin
      if (store_byte && !reset_now) mem[wr_spec[DEPTH_LOG2-1:0]] <= data_out;
   end

   // Edge registers track the bus even through reset so a transaction that is
   // still active when reset lifts is not mistaken for a new start.
   always_ff @(posedge clk48mhz) begin
      ta_q <= transaction_active;
      ds_q <= data_strobe;
   end
endmodule

// File: tb/tb_usb_bulk_out_ep.sv
// Self-checking bench for usb_bulk_out_ep: token table, directed corner sequences
// and randomized packets checked against a queue-based endpoint model.
module tb_usb_bulk_out_ep;
   localparam int CAP  = 128;
   localparam int MAXP = 64;

   logic       clk48mhz = 1'b0;
   logic       rst = 1'b0, usb_rst = 1'b0;
   logic       ep_enable = 1'b1, ep_halt = 1'b0;
   logic       transaction_active = 1'b0;
   logic [3:0] endpoint = 4'd0;
   logic       direction_in = 1'b0, setup = 1'b0;
   logic       data_strobe = 1'b0;
   logic [7:0] data_out = 8'h00;
   logic       success = 1'b0;
   logic [1:0] handshake;
   logic       data_toggle, claim, fifo_empty;
   logic [7:0] fifo_data;
   logic       fifo_pop = 1'b0;
   logic [7:0] fifo_count;

   int errors = 0;
   int checks = 0;

   logic [7:0] mq[$];
   bit         mtog = 1'b0;

   usb_bulk_out_ep #(.EP_NUM(2), .DEPTH_LOG2(7), .MAX_PKT(64)) dut (
      .clk48mhz(clk48mhz), .rst(rst), .usb_rst(usb_rst),
      .ep_enable(ep_enable), .ep_halt(ep_halt),
      .transaction_active(transaction_active), .endpoint(endpoint),
      .direction_in(direction_in), .setup(setup),
      .data_strobe(data_strobe), .data_out(data_out), .success(success),
      .handshake(handshake), .data_toggle(data_toggle), .claim(claim),
      .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_pop(fifo_pop),
      .fifo_count(fifo_count)
   );

   always #5 clk48mhz = ~clk48mhz;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk48mhz);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_fifo(input string nm);
      chk({nm, "_count"}, 32'(fifo_count), 32'(mq.size()));
      chk({nm, "_empty"}, 32'(fifo_empty), 32'(mq.size() == 0));
      chk({nm, "_toggle"}, 32'(data_toggle), 32'(mtog));
      if (mq.size() != 0) chk({nm, "_head"}, 32'(fifo_data), 32'(mq[0]));
   endtask

   task automatic send_byte(input logic [7:0] b);
      data_out = b;
      data_strobe = 1'b1;
      tick();
      data_strobe = 1'b0;
      tick();
   endtask

   function automatic logic [1:0] model_hs();
      if (ep_halt) return 2'b11;
      if (!ep_enable) return 2'b01;
      if (CAP - mq.size() < MAXP) return 2'b10;
      return 2'b00;
   endfunction

   // One OUT transaction to EP2. fixed=1 sends 11 22 33 44 ...
   task automatic out_pkt(input int n, input bit succ, input bit fixed);
      logic [7:0] pkt[$];
      logic [7:0] b;
      logic [1:0] exp_hs;
      exp_hs = model_hs();
      endpoint = 4'd2; direction_in = 1'b0; setup = 1'b0;
      transaction_active = 1'b1;
      tick();
      chk("out_claim", 32'(claim), 32'd1);
      chk("out_hs", 32'(handshake), 32'(exp_hs));
      for (int i = 0; i < n; i++) begin
         b = fixed ? 8'(8'h11 * (i + 1)) : 8'($urandom);
         pkt.push_back(b);
         send_byte(b);
      end
      if (succ) begin
         success = 1'b1;
         tick();
         success = 1'b0;
         chk("out_hs_hold", 32'(handshake), 32'(exp_hs));
      end
      transaction_active = 1'b0;
      tick();
      chk("out_release_claim", 32'(claim), 32'd0);
      chk("out_release_hs", 32'(handshake), 32'd1);
      tick();
      if (exp_hs == 2'b00 && succ && n <= MAXP) begin
         foreach (pkt[i]) mq.push_back(pkt[i]);
         mtog = ~mtog;
      end
      chk_fifo("out");
   endtask

   task automatic pop_n(input int k);
      for (int i = 0; i < k; i++) begin
         if (mq.size() == 0) break;
         chk("pop_data", 32'(fifo_data), 32'(mq[0]));
         fifo_pop = 1'b1;
         tick();
         void'(mq.pop_front());
      end
      fifo_pop = 1'b0;
      chk_fifo("pop");
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
      mq.delete();
      mtog = 1'b0;
   endtask

   typedef struct {
      logic [3:0] ep;
      logic       din;
      logic       stp;
      logic       halt;
      logic       en;
      logic       exp_claim;
      logic [1:0] exp_hs;
   } tok_vec_t;

   tok_vec_t tv[8];

   initial begin
      tv[0] = '{4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00};
      tv[1] = '{4'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b11};
      tv[2] = '{4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01};
      tv[3] = '{4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b11};
      tv[4] = '{4'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01};
      tv[5] = '{4'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01};
      tv[6] = '{4'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01};
      tv[7] = '{4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01};

      rst = 1'b0;
      tick(); tick();
      chk("rst_hs", 32'(handshake), 32'd1);
      chk("rst_claim", 32'(claim), 32'd0);
      chk("rst_toggle", 32'(data_toggle), 32'd0);
      chk("rst_empty", 32'(fifo_empty), 32'd1);
      chk("rst_data", 32'(fifo_data), 32'd0);
      chk("rst_count", 32'(fifo_count), 32'd0);
      rst = 1'b1;
      tick();

      // Token table
      for (int i = 0; i < 8; i++) begin
         ep_halt = tv[i].halt; ep_enable = tv[i].en;
         endpoint = tv[i].ep; direction_in = tv[i].din; setup = tv[i].stp;
         transaction_active = 1'b1;
         tick();
         chk("tok_claim", 32'(claim), 32'(tv[i].exp_claim));
         chk("tok_hs", 32'(handshake), 32'(tv[i].exp_hs));
         send_byte(8'hA5);
         transaction_active = 1'b0;
         tick();
         chk("tok_release", 32'(claim), 32'd0);
         tick();
         chk_fifo("tok");
      end
      ep_halt = 1'b0; ep_enable = 1'b1;

      // Basic packet, then drop before success, then same packet again
      out_pkt(4, 1'b1, 1'b1);
      pop_n(4);
      out_pkt(4, 1'b0, 1'b1);
      out_pkt(4, 1'b1, 1'b1);
      chk("relanded_head", 32'(fifo_data), 32'h11);

      // Pop while empty is ignored
      pop_n(4);
      fifo_pop = 1'b1;
      tick();
      fifo_pop = 1'b0;
      chk_fifo("empty_pop");

      // Commit and pop in the same cycle
      out_pkt(4, 1'b1, 1'b1);
      endpoint = 4'd2; transaction_active = 1'b1;
      tick();
      send_byte(8'h5A); send_byte(8'h6B); send_byte(8'h7C);
      success = 1'b1; fifo_pop = 1'b1;
      tick();
      success = 1'b0; fifo_pop = 1'b0;
      void'(mq.pop_front());
      mq.push_back(8'h5A); mq.push_back(8'h6B); mq.push_back(8'h7C);
      mtog = ~mtog;
      chk_fifo("commit_pop");
      transaction_active = 1'b0;
      tick(); tick();
      pop_n(6);

      // Zero-length packet flips the toggle only
      out_pkt(0, 1'b1, 1'b0);

      // Fill: two full packets, NAK until 64 bytes are free
      out_pkt(64, 1'b1, 1'b0);
      out_pkt(64, 1'b1, 1'b0);
      out_pkt(5, 1'b1, 1'b0);
      pop_n(1);
      out_pkt(5, 1'b1, 1'b0);
      pop_n(63);
      out_pkt(10, 1'b1, 1'b0);
      pop_n(200);

      // Oversize packet is dropped
      out_pkt(65, 1'b1, 1'b0);

      // Pointer wrap
      for (int i = 0; i < 3; i++) begin
         out_pkt(64, 1'b1, 1'b0);
         pop_n(64);
      end

      // Bus reset mid-receive
      out_pkt(10, 1'b1, 1'b0);
      endpoint = 4'd2; transaction_active = 1'b1;
      tick();
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
      usb_rst = 1'b1;
      tick();
      mq.delete(); mtog = 1'b0;
      chk("usbrst_claim", 32'(claim), 32'd0);
      chk("usbrst_hs", 32'(handshake), 32'd1);
      chk("usbrst_data", 32'(fifo_data), 32'd0);
      chk_fifo("usbrst");
      usb_rst = 1'b0;
      tick();
      chk("usbrst_no_false_start", 32'(claim), 32'd0);
      transaction_active = 1'b0;
      tick(); tick();

      // Randomized traffic against the model
      for (int it = 0; it < 40; it++) begin
         int r;
         r = int'($urandom_range(0, 9));
         ep_halt = ($urandom_range(0, 9) == 0);
         ep_enable = ($urandom_range(0, 9) != 0);
         if (r == 0) begin
            endpoint = 4'($urandom_range(0, 15));
            direction_in = 1'b1; setup = ($urandom_range(0, 1) == 1);
            transaction_active = 1'b1;
            tick();
            chk("rnd_foreign_claim", 32'(claim), 32'd0);
            transaction_active = 1'b0; direction_in = 1'b0; setup = 1'b0;
            tick(); tick();
         end else begin
            out_pkt(int'($urandom_range(0, 66)), ($urandom_range(0, 4) != 0), 1'b0);
         end
         if ($urandom_range(0, 2) == 0 && mq.size() != 0)
            pop_n(int'($urandom_range(1, mq.size())));
      end
      ep_halt = 1'b0; ep_enable = 1'b1;
      pop_n(CAP);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
